// File: rtl/fft_butterfly_r2.sv
// Pipelined radix-2 DIT butterfly on signed Q1.(WIDTH-1) complex samples: X = a + W*b, Y = a - W*b.
// Registered inputs, product stage, rounding stage and saturating output stage give a latency of 3 edges.
module fft_butterfly_r2 #(
   parameter int WIDTH = 16,
   parameter int SCALE = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic signed [WIDTH-1:0] a_re,
   input  logic signed [WIDTH-1:0] a_im,
   input  logic signed [WIDTH-1:0] b_re,
   input  logic signed [WIDTH-1:0] b_im,
   input  logic signed [WIDTH-1:0] w_re,
   input  logic signed [WIDTH-1:0] w_im,
   output logic                    out_valid,
   output logic signed [WIDTH-1:0] x_re,
   output logic signed [WIDTH-1:0] x_im,
   output logic signed [WIDTH-1:0] y_re,
   output logic signed [WIDTH-1:0] y_im,
   output logic                    ovf
);

   localparam int MW = 2 * WIDTH;
   localparam int PW = 2 * WIDTH + 1;
   localparam int W2 = WIDTH + 2;
   localparam int W3 = WIDTH + 3;
   localparam logic signed [PW-1:0] RND  = PW'(64'd1 << (WIDTH - 2));
   localparam logic signed [W3-1:0] SMAX = W3'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
   localparam logic signed [W3-1:0] SMIN = ~SMAX;
   localparam logic signed [W3-1:0] ONE  = W3'(1);

   logic signed [WIDTH-1:0] r_a0_re, r_a0_im, r_b0_re, r_b0_im, r_w0_re, r_w0_im;
   logic                    r_v0;
   logic signed [MW-1:0]    r_m_rr, r_m_ii, r_m_ri, r_m_ir;
   logic signed [WIDTH-1:0] r_a1_re, r_a1_im;
   logic                    r_v1;
   logic signed [W2-1:0]    r_p_re, r_p_im;
   logic signed [WIDTH-1:0] r_a2_re, r_a2_im;
   logic                    r_v2;
   logic signed [WIDTH-1:0] r_o [4];
   logic                    r_ovf;
   logic                    r_v3;

   logic signed [PW-1:0]    w_p_re, w_p_im;
   logic signed [W3-1:0]    w_sum [4];
   logic signed [W3-1:0]    w_scl [4];
   logic signed [WIDTH-1:0] w_sat [4];
   logic [3:0]              w_ovf_lane;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a0_re <= '0; r_a0_im <= '0;
         r_b0_re <= '0; r_b0_im <= '0;
         r_w0_re <= '0; r_w0_im <= '0;
         r_v0    <= 1'b0;
      end else begin
         r_a0_re <= a_re; r_a0_im <= a_im;
         r_b0_re <= b_re; r_b0_im <= b_im;
         r_w0_re <= w_re; r_w0_im <= w_im;
         r_v0    <= in_valid;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_m_rr  <= '0; r_m_ii <= '0; r_m_ri <= '0; r_m_ir <= '0;
         r_a1_re <= '0; r_a1_im <= '0;
         r_v1    <= 1'b0;
      end else begin
         r_m_rr  <= MW'(r_b0_re) * MW'(r_w0_re);
         r_m_ii  <= MW'(r_b0_im) * MW'(r_w0_im);
         r_m_ri  <= MW'(r_b0_re) * MW'(r_w0_im);
         r_m_ir  <= MW'(r_b0_im) * MW'(r_w0_re);
         r_a1_re <= r_a0_re; r_a1_im <= r_a0_im;
         r_v1    <= r_v0;
      end
   end

   assign w_p_re = PW'(r_m_rr) - PW'(r_m_ii);
   assign w_p_im = PW'(r_m_ri) + PW'(r_m_ir);

   // Round half-up back to Q1.(WIDTH-1); two guard bits cover the (-1)*(-1) corners.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_p_re  <= '0; r_p_im  <= '0;
         r_a2_re <= '0; r_a2_im <= '0;
         r_v2    <= 1'b0;
      end else begin
         r_p_re  <= W2'((w_p_re + RND) >>> (WIDTH - 1));
         r_p_im  <= W2'((w_p_im + RND) >>> (WIDTH - 1));
         r_a2_re <= r_a1_re; r_a2_im <= r_a1_im;
         r_v2    <= r_v1;
      end
   end

   // Lanes: 0 = x_re, 1 = x_im, 2 = y_re, 3 = y_im.
   assign w_sum[0] = W3'(r_a2_re) + W3'(r_p_re);
   assign w_sum[1] = W3'(r_a2_im) + W3'(r_p_im);
   assign w_sum[2] = W3'(r_a2_re) - W3'(r_p_re);
   assign w_sum[3] = W3'(r_a2_im) - W3'(r_p_im);

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         if (SCALE != 0) begin : g_scl
            assign w_scl[gi] = (w_sum[gi] + ONE) >>> 1;
         end else begin : g_noscl
            assign w_scl[gi] = w_sum[gi];
         end
         assign w_ovf_lane[gi] = (w_scl[gi] > SMAX) || (w_scl[gi] < SMIN);
         assign w_sat[gi] = (w_scl[gi] > SMAX) ? WIDTH'(SMAX) :
                            (w_scl[gi] < SMIN) ? WIDTH'(SMIN) : WIDTH'(w_scl[gi]);
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) r_o[i] <= '0;
         r_ovf <= 1'b0;
         r_v3  <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) r_o[i] <= w_sat[i];
         r_ovf <= |w_ovf_lane;
         r_v3  <= r_v2;
      end
   end

   assign x_re      = r_o[0];
   assign x_im      = r_o[1];
   assign y_re      = r_o[2];
   assign y_im      = r_o[3];
   assign ovf       = r_ovf;
   assign out_valid = r_v3;

endmodule

// File: tb/tb_fft_butterfly_r2.sv
// Scoreboard bench: unscaled and scaled butterflies share stimulus; a real-arithmetic model predicts results.
module tb_fft_butterfly_r2;

   typedef struct {
      int xr, xi, yr, yi;
      int ov;
      int cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0;
   logic signed [15:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0, w_re = '0, w_im = '0;
   logic ov0, ov1, of0, of1;
   logic signed [15:0] xr0, xi0, yr0, yi0, xr1, xi1, yr1, yi1;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   exp_t q0[$];
   exp_t q1[$];

   fft_butterfly_r2 #(.WIDTH(16), .SCALE(0)) u_dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
      .out_valid(ov0), .x_re(xr0), .x_im(xi0), .y_re(yr0), .y_im(yi0), .ovf(of0));

   fft_butterfly_r2 #(.WIDTH(16), .SCALE(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
      .out_valid(ov1), .x_re(xr1), .x_im(xi1), .y_re(yr1), .y_im(yi1), .ovf(of1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", name, got, exp);
      end
   endtask

   function automatic int clamp(input int v, inout int ov);
      if (v > 32767) begin ov = 1; return 32767; end
      if (v < -32768) begin ov = 1; return -32768; end
      return v;
   endfunction

   // Exact in double precision: products stay below 2^31.
   function automatic exp_t model(input int ar, ai, br, bi, wr, wi, input int sc, input int c);
      exp_t e;
      real pr, pi;
      int p_re, p_im, ov;
      int s[4];
      pr = real'(br) * real'(wr) - real'(bi) * real'(wi);
      pi = real'(br) * real'(wi) + real'(bi) * real'(wr);
      p_re = int'($floor(pr / 32768.0 + 0.5));
      p_im = int'($floor(pi / 32768.0 + 0.5));
      s[0] = ar + p_re; s[1] = ai + p_im; s[2] = ar - p_re; s[3] = ai - p_im;
      ov = 0;
      for (int i = 0; i < 4; i++) begin
         if (sc != 0) s[i] = int'($floor(real'(s[i]) / 2.0 + 0.5));
         s[i] = clamp(s[i], ov);
      end
      e.xr = s[0]; e.xi = s[1]; e.yr = s[2]; e.yi = s[3]; e.ov = ov; e.cyc = c;
      return e;
   endfunction

   function automatic int rnd16();
      logic signed [15:0] v;
      v = 16'($urandom);
      return int'(v);
   endfunction

   task automatic issue(input int ar, ai, br, bi, wr, wi);
      a_re = 16'(ar); a_im = 16'(ai); b_re = 16'(br); b_im = 16'(bi); w_re = 16'(wr); w_im = 16'(wi);
      in_valid = 1'b1;
      q0.push_back(model(ar, ai, br, bi, wr, wi, 0, cyc + 1));
      q1.push_back(model(ar, ai, br, bi, wr, wi, 1, cyc + 1));
      $display("issue @%0d a=(%0d,%0d) b=(%0d,%0d) w=(%0d,%0d)", cyc + 1, ar, ai, br, bi, wr, wi);
      @(negedge clk);
   endtask

   task automatic idle();
      in_valid = 1'b0;
      a_re = 16'(rnd16()); a_im = 16'(rnd16()); b_re = 16'(rnd16());
      b_im = 16'(rnd16()); w_re = 16'(rnd16()); w_im = 16'(rnd16());
      @(negedge clk);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ov0"}, int'(ov0), 0);
      chk({tag, "_ov1"}, int'(ov1), 0);
      chk({tag, "_ovf"}, int'(of0) + int'(of1), 0);
      chk({tag, "_x0"}, int'(xr0) | int'(xi0), 0);
      chk({tag, "_y0"}, int'(yr0) | int'(yi0), 0);
      chk({tag, "_x1"}, int'(xr1) | int'(xi1), 0);
      chk({tag, "_y1"}, int'(yr1) | int'(yi1), 0);
   endtask

   task automatic cmp_out(input int inst, input exp_t e, input int xr, xi, yr, yi, of);
      string p;
      p = (inst == 0) ? "s0" : "s1";
      $display("out%0d @%0d x=(%0d,%0d) y=(%0d,%0d) ovf=%0d", inst, cyc, xr, xi, yr, yi, of);
      chk({p, "_latency"}, cyc - e.cyc, 3);
      chk({p, "_x_re"}, xr, e.xr);
      chk({p, "_x_im"}, xi, e.xi);
      chk({p, "_y_re"}, yr, e.yr);
      chk({p, "_y_im"}, yi, e.yi);
      chk({p, "_ovf"}, of, e.ov);
   endtask

   always @(negedge clk) begin
      if (!rst && ov0) begin
         if (q0.size() == 0) chk("s0_unexpected_valid", 1, 0);
         else cmp_out(0, q0.pop_front(), int'(xr0), int'(xi0), int'(yr0), int'(yi0), int'(of0));
      end
      if (!rst && ov1) begin
         if (q1.size() == 0) chk("s1_unexpected_valid", 1, 0);
         else cmp_out(1, q1.pop_front(), int'(xr1), int'(xi1), int'(yr1), int'(yi1), int'(of1));
      end
   end

   initial begin
      #3 chk_zero("reset_async");
      repeat (3) @(negedge clk);
      chk_zero("reset_clocked");
      rst = 1'b0;
      idle();

      // Directed corners, spaced so each latency is seen in isolation.
      issue(32767, 0, 32767, 0, 32767, 0);
      repeat (5) idle();
      issue(32767, 0, 0, 0, 32767, 0);
      repeat (5) idle();
      issue(8192, 0, 8192, 0, 0, 32767);
      repeat (5) idle();
      issue(-32768, 0, 32767, 0, -32768, 0);
      repeat (5) idle();

      // Back-to-back ordering.
      issue(1000, -2000, 3000, 4000, 23170, -23170);
      issue(-5, 7, -32768, -32768, -32768, -32768);
      issue(12345, 32767, -32768, 32767, 32767, 32767);
      repeat (5) idle();

      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 9) < 7) begin
            int wr;
            wr = ($urandom_range(0, 7) == 0) ? -32768 : rnd16();
            issue(rnd16(), rnd16(), rnd16(), rnd16(), wr, rnd16());
         end else begin
            idle();
         end
      end
      repeat (5) idle();

      // Reset with two samples in flight.
      issue(20000, 100, 300, -400, 16384, 16384);
      issue(-20000, -100, 500, 600, -16384, 8192);
      in_valid = 1'b0;
      @(posedge clk);
      #2;
      q0.delete();
      q1.delete();
      rst = 1'b1;
      #1 chk_zero("reset_midstream");
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (6) idle();
      issue(-1234, 4321, 32767, -32768, 0, -32768);
      repeat (6) idle();

      for (int t = 0; t < 20 && (q0.size() != 0 || q1.size() != 0); t++) @(negedge clk);
      chk("drain_s0", q0.size(), 0);
      chk("drain_s1", q1.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
